// File: rtl/core_bridge_target_cmdq_if.sv
// Bridge register bus plus command-in / response-out handshakes of the target command issuer.
interface core_bridge_target_cmdq_if #(
    parameter int NPARAM = 4
);
    logic [31:0]          bridge_addr;
    logic                 bridge_rd;
    logic [31:0]          bridge_rd_data;
    logic                 bridge_wr;
    logic [31:0]          bridge_wr_data;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [15:0]          cmd_code;
    logic [32*NPARAM-1:0] cmd_param;
    logic                 rsp_valid;
    logic [15:0]          rsp_result;
    logic                 rsp_timeout;
    logic [31:0]          rsp_data;

    modport slave (
        input  bridge_addr, bridge_rd, bridge_wr, bridge_wr_data,
        input  cmd_valid, cmd_code, cmd_param,
        output bridge_rd_data, cmd_ready,
        output rsp_valid, rsp_result, rsp_timeout, rsp_data
    );

    modport master (
        output bridge_addr, bridge_rd, bridge_wr, bridge_wr_data,
        output cmd_valid, cmd_code, cmd_param,
        input  bridge_rd_data, cmd_ready,
        input  rsp_valid, rsp_result, rsp_timeout, rsp_data
    );
endinterface

// File: rtl/core_bridge_target_cmdq.sv
// Target->host command issuer: queues commands, publishes them one at a time in the
// 0xF8xx10xx bridge window and reports the host's reply (or a timeout) per command.
//
// state | meaning
// IDLE  | nothing in flight, waiting for a queued command
// ISSUE | pop head, load params, publish {"cm", code} in target_0
// WAIT  | waiting for "ok" in target_0 or for the reply timer to expire
// DONE  | one-cycle response pulse; cancel target_0 on timeout
module core_bridge_target_cmdq #(
    parameter int QDEPTH      = 4,
    parameter int NPARAM      = 4,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      bridge_endian_little,
    core_bridge_target_cmdq_if.slave  bus,
    output logic [$clog2(QDEPTH):0]   q_count,
    output logic                      busy
);
    localparam int          AW       = $clog2(QDEPTH);
    localparam logic [AW:0] FULL     = (AW+1)'(QDEPTH);
    localparam logic [31:0] TMO_LAST = (TIMEOUT_CYC == 0) ? 32'd0 : 32'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t state_q, state_d;

    function automatic logic [31:0] bswap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    logic [1:0]           le_sync;
    logic                 le;
    logic                 hit;
    logic [7:0]           offset;
    logic [31:0]          wdata;
    logic                 wr_t0;
    logic                 wr_rsp;
    logic [31:0]          rd_val;
    logic [31:0]          target_0;
    logic [31:0]          eff_t0;
    logic [31:0]          param_q [NPARAM];
    logic [31:0]          resp_q [4];
    logic [31:0]          timer_q;
    logic [15:0]          res_q;
    logic                 to_q;
    logic [31:0]          rd_data_q;
    logic                 ok_now;
    logic                 expired;

    logic [15:0]          code_mem [QDEPTH];
    logic [32*NPARAM-1:0] param_mem [QDEPTH];
    logic [AW-1:0]        wptr, rptr;
    logic [AW:0]          count;
    logic                 push, pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) le_sync <= 2'b00;
        else          le_sync <= {le_sync[0], bridge_endian_little};
    end
    assign le = le_sync[1];

    assign hit    = bus.bridge_addr ==? 32'hF8??10??;
    assign offset = bus.bridge_addr[7:0];
    assign wdata  = le ? bswap(bus.bridge_wr_data) : bus.bridge_wr_data;
    assign wr_t0  = bus.bridge_wr & hit & (offset == 8'h00);
    assign wr_rsp = bus.bridge_wr & hit & (offset[7:4] == 4'h4) & (offset[1:0] == 2'b00);

    // A same-cycle host write is seen by WAIT so an "ok" racing the timer still wins.
    assign eff_t0  = wr_t0 ? wdata : target_0;
    assign ok_now  = (eff_t0[31:16] == 16'h6F6B);
    assign expired = (TIMEOUT_CYC != 0) && (timer_q == TMO_LAST);

    assign bus.cmd_ready = (count != FULL);
    assign push          = bus.cmd_valid & bus.cmd_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            code_mem[wptr]  <= bus.cmd_code;
            param_mem[wptr] <= bus.cmd_param;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE:    if (count != '0) state_d = ISSUE;
            ISSUE: begin
                pop     = 1'b1;
                state_d = WAIT;
            end
            WAIT:    if (ok_now || expired) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_val = '0;
        if (offset == 8'h00)      rd_val = target_0;
        else if (offset == 8'h04) rd_val = 32'h0000_0020;
        else if (offset == 8'h08) rd_val = 32'h0000_0040;
        else if (offset[7:4] == 4'h4 && offset[1:0] == 2'b00) rd_val = resp_q[offset[3:2]];
        for (int i = 0; i < NPARAM; i++) begin
            if (offset == 8'(32 + 4*i)) rd_val = param_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            target_0  <= '0;
            timer_q   <= '0;
            res_q     <= '0;
            to_q      <= 1'b0;
            rd_data_q <= '0;
            for (int i = 0; i < NPARAM; i++) param_q[i] <= '0;
            for (int i = 0; i < 4; i++)      resp_q[i]  <= '0;
        end else begin
            state_q <= state_d;

            // Issuer-side writes to target_0 take priority over the host.
            if (state_q == ISSUE)             target_0 <= {16'h636D, code_mem[rptr]};
            else if (state_q == DONE && to_q) target_0 <= '0;
            else if (wr_t0)                   target_0 <= wdata;

            if (state_q == ISSUE) begin
                for (int i = 0; i < 4; i++)      resp_q[i]  <= '0;
                for (int i = 0; i < NPARAM; i++) param_q[i] <= param_mem[rptr][32*i +: 32];
            end else if (wr_rsp) begin
                resp_q[offset[3:2]] <= wdata;
            end

            if (state_q == ISSUE)                           timer_q <= '0;
            else if (state_q == WAIT && timer_q != '1)      timer_q <= timer_q + 32'd1;

            if (state_q == WAIT && state_d == DONE) begin
                res_q <= ok_now ? eff_t0[15:0] : 16'hFFFF;
                to_q  <= ~ok_now;
            end

            if (bus.bridge_rd && hit) rd_data_q <= le ? bswap(rd_val) : rd_val;
        end
    end

    assign bus.bridge_rd_data = rd_data_q;
    assign bus.rsp_valid      = (state_q == DONE);
    assign bus.rsp_result     = (state_q == DONE) ? res_q : 16'h0000;
    assign bus.rsp_timeout    = (state_q == DONE) & to_q;
    assign bus.rsp_data       = (state_q == DONE) ? resp_q[0] : 32'h0;
    assign q_count            = count;
    assign busy               = (state_q != IDLE);
endmodule

// File: tb/tb_core_bridge_target_cmdq.sv
// Directed bench for core_bridge_target_cmdq: single command in both endians, queue full,
// reply timeout, response data and reset while a command is outstanding.
module tb_core_bridge_target_cmdq;
    localparam int QDEPTH      = 4;
    localparam int NPARAM      = 4;
    localparam int TIMEOUT_CYC = 100;
    localparam logic [31:0] A_T0   = 32'hF8AB_1000;
    localparam logic [31:0] A_P4   = 32'hF800_1004;
    localparam logic [31:0] A_P8   = 32'hF800_1008;
    localparam logic [31:0] A_PAR0 = 32'hF800_1020;
    localparam logic [31:0] A_PAR3 = 32'hF800_102C;
    localparam logic [31:0] A_R0   = 32'hF8CD_1040;
    localparam logic [31:0] A_MISS = 32'hF800_2000;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   bridge_endian_little = 1'b0;
    logic [$clog2(QDEPTH):0] q_count;
    logic                   busy;
    int                     checks = 0;
    int                     errors = 0;
    int                     max_q = 0;

    core_bridge_target_cmdq_if #(.NPARAM(NPARAM)) bus();

    core_bridge_target_cmdq #(
        .QDEPTH(QDEPTH), .NPARAM(NPARAM), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bridge_endian_little(bridge_endian_little),
        .bus(bus),
        .q_count(q_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (int'(q_count) > max_q) max_q = int'(q_count);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.bridge_addr    = a;
        bus.bridge_wr_data = d;
        bus.bridge_wr      = 1'b1;
        @(negedge clk);
        bus.bridge_wr      = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.bridge_addr = a;
        bus.bridge_rd   = 1'b1;
        @(negedge clk);
        bus.bridge_rd   = 1'b0;
        d = bus.bridge_rd_data;
    endtask

    task automatic enqueue(input logic [15:0] code, input logic [32*NPARAM-1:0] prm);
        int n;
        n = 0;
        @(negedge clk);
        bus.cmd_code  = code;
        bus.cmd_param = prm;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    // Waits (bounded) for the response pulse, checks it and that it lasts one cycle.
    task automatic wait_rsp(input string tag, input logic [15:0] res,
                            input logic tmo, input logic [31:0] data);
        int n;
        n = 0;
        while (!bus.rsp_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rsp_valid"},   32'(bus.rsp_valid),   32'd1);
        chk({tag, "_rsp_result"},  32'(bus.rsp_result),  32'(res));
        chk({tag, "_rsp_timeout"}, 32'(bus.rsp_timeout), 32'(tmo));
        chk({tag, "_rsp_data"},    bus.rsp_data,         data);
        @(negedge clk);
        chk({tag, "_rsp_pulse"},   32'(bus.rsp_valid),   32'd0);
    endtask

    // Polls target_0 until a command is published, checks its code, replies "ok".
    task automatic serve(input string tag, input logic [15:0] code, input logic [15:0] res);
        logic [31:0] d;
        int n;
        d = '0;
        n = 0;
        while (d[31:16] != 16'h636D && n < 40) begin
            bus_rd(A_T0, d);
            n++;
        end
        chk({tag, "_issue"}, d, {16'h636D, code});
        bus_wr(A_T0, {16'h6F6B, res});
        wait_rsp(tag, res, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] d;
        int n;
        int cyc;

        bus.bridge_addr    = '0;
        bus.bridge_rd      = 1'b0;
        bus.bridge_wr      = 1'b0;
        bus.bridge_wr_data = '0;
        bus.cmd_valid      = 1'b0;
        bus.cmd_code       = '0;
        bus.cmd_param      = '0;

        wait_cycles(3);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready),   32'd1);
        chk("rst_q_count",   32'(q_count),         32'd0);
        chk("rst_busy",      32'(busy),            32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid),   32'd0);
        chk("rst_rd_data",   bus.bridge_rd_data,   32'h0);
        bus_rd(A_T0, d); chk("rst_target_0", d, 32'h0);
        bus_rd(A_P4, d); chk("rst_ptr_4",    d, 32'h20);
        bus_rd(A_P8, d); chk("rst_ptr_8",    d, 32'h40);

        // T1: single command, big-endian
        enqueue(16'h0140, {32'd4, 32'd3, 32'd2, 32'd1});
        wait_cycles(3);
        bus_rd(A_PAR0, d); chk("t1_param0",   d, 32'd1);
        bus_rd(A_PAR3, d); chk("t1_param3",   d, 32'd4);
        bus_rd(A_T0, d);   chk("t1_target_0", d, 32'h636D_0140);
        bus_wr(A_T0, 32'h6F6B_0000);
        wait_rsp("t1", 16'h0000, 1'b0, 32'h0);

        // T2: little-endian host
        bridge_endian_little = 1'b1;
        wait_cycles(3);
        enqueue(16'h0140, {32'd4, 32'd3, 32'd2, 32'd1});
        wait_cycles(3);
        bus_rd(A_T0, d);   chk("t2_target_0", d, 32'h4001_6D63);
        bus_rd(A_PAR0, d); chk("t2_param0",   d, 32'h0100_0000);
        bus_wr(A_T0, 32'h0000_6B6F);
        wait_rsp("t2", 16'h0000, 1'b0, 32'h0);
        bridge_endian_little = 1'b0;
        wait_cycles(3);

        // T3: five back-to-back pushes; one goes in flight, four fill the queue
        max_q = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.cmd_code  = 16'h0200 + 16'(k);
            bus.cmd_param = {4{32'(k)}};
            n = 0;
            while (!bus.cmd_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        chk("t3_q_full",    32'(q_count),       32'd4);
        chk("t3_ready_low", 32'(bus.cmd_ready), 32'd0);
        chk("t3_busy",      32'(busy),          32'd1);
        for (int k = 0; k < 5; k++) serve("t3", 16'h0200 + 16'(k), 16'h0020 + 16'(k));
        chk("t3_q_max", 32'(max_q), 32'd4);
        chk("t3_q_empty", 32'(q_count), 32'd0);

        // T4: timeout; ISSUE cycle followed by TIMEOUT_CYC wait cycles, then DONE
        enqueue(16'h0400, '0);
        n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.cmd_code  = 16'h0401;
        bus.cmd_param = '0;
        bus.cmd_valid = 1'b1;
        cyc = 0;
        while (!bus.rsp_valid && cyc < 300) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            cyc++;
        end
        chk("t4_latency",    32'(cyc),             32'(TIMEOUT_CYC + 1));
        chk("t4_rsp_result", 32'(bus.rsp_result),  32'h0000_FFFF);
        chk("t4_rsp_timeout",32'(bus.rsp_timeout), 32'd1);
        bus_rd(A_T0, d); chk("t4_cancelled", d, 32'h0);
        serve("t4_next", 16'h0401, 16'h0007);

        // T5: response data plus an out-of-window write that must be ignored
        enqueue(16'h0500, '0);
        wait_cycles(3);
        bus_wr(A_MISS, 32'h6F6B_0099);
        bus_rd(A_T0, d); chk("t5_miss_ignored", d, 32'h636D_0500);
        bus_wr(A_R0, 32'hDEAD_BEEF);
        bus_rd(A_R0, d); chk("t5_resp_rd", d, 32'hDEAD_BEEF);
        bus_wr(A_T0, 32'h6F6B_0003);
        wait_rsp("t5", 16'h0003, 1'b0, 32'hDEAD_BEEF);

        // T6: reset while one command waits and two are queued
        enqueue(16'h0601, '0);
        enqueue(16'h0602, '0);
        enqueue(16'h0603, '0);
        chk("t6_pre_q", 32'(q_count), 32'd2);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("t6_q_count", 32'(q_count), 32'd0);
        chk("t6_busy",    32'(busy),    32'd0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.rsp_valid) n++;
            @(negedge clk);
        end
        chk("t6_no_rsp", 32'(n), 32'd0);
        bus_rd(A_T0, d); chk("t6_target_0", d, 32'h0);
        enqueue(16'h0610, '0);
        serve("t6_new", 16'h0610, 16'h0011);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
